// File: rtl/hex_entry_pkg.sv
// Shared constants for the hex entry block: button indices and edit FSM encoding.
package hex_entry_pkg;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ENTER = 4;
    localparam int NUM_BTN   = 5;

    typedef enum logic {
        EDIT = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/hex_entry_button_conditioner.sv
// One raw pushbutton -> synchronised, debounced, single-cycle press pulse,
// with optional auto-repeat while the button stays held.
module button_conditioner #(
    parameter int DEBOUNCE_BITS = 16,
    parameter int REPEAT_BITS   = 22,
    parameter bit REPEAT_EN     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic                     r_sync1;
    logic                     r_sync2;
    logic                     r_stable;
    logic                     r_stable_d;
    logic                     r_press;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic [REPEAT_BITS-1:0]   r_rep_cnt;
    logic                     w_rise;
    logic                     w_wrap;

    assign w_rise  = r_stable & ~r_stable_d;
    // Repeat counter only advances after the initial press, so the first
    // repeat lands a full counter period after it.
    assign w_wrap  = REPEAT_EN && r_stable && !w_rise && (&r_rep_cnt);
    assign o_press = r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
            r_db_cnt   <= '0;
            r_rep_cnt  <= '0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;

            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (&r_db_cnt) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DEBOUNCE_BITS'(1);
            end

            if (!REPEAT_EN || !r_stable || w_rise) begin
                r_rep_cnt <= '0;
            end else begin
                r_rep_cnt <= r_rep_cnt + REPEAT_BITS'(1);
            end

            r_press <= w_rise | w_wrap;
        end
    end

endmodule

// File: rtl/hex_entry.sv
// Pushbutton-driven 4-digit hex editor with cursor and a valid/ready commit
// port; the live word feeds the display driver directly.
module hex_entry
    import hex_entry_pkg::*;
#(
    parameter int  DIGITS        = 4,
    parameter int  DEBOUNCE_BITS = 16,
    parameter int  REPEAT_BITS   = 22,
    localparam int CW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_BTN-1:0]    i_btn,
    output logic [4*DIGITS-1:0]   o_values,
    output logic [CW-1:0]         o_cursor,
    output logic                  o_commit_valid,
    output logic [4*DIGITS-1:0]   o_commit_data,
    input  logic                  i_commit_ready
);

    // state | meaning
    // EDIT  | no commit outstanding; enter captures values and raises valid
    // WAIT  | commit held until accepted; edits still apply, enter ignored

    logic [NUM_BTN-1:0]  w_press;
    logic [3:0]          w_digit;
    state_e              r_state;
    logic [4*DIGITS-1:0] r_values;
    logic [CW-1:0]       r_cursor;
    logic                r_commit_valid;
    logic [4*DIGITS-1:0] r_commit_data;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        button_conditioner #(
            .DEBOUNCE_BITS (DEBOUNCE_BITS),
            .REPEAT_BITS   (REPEAT_BITS),
            .REPEAT_EN     ((g == BTN_UP) || (g == BTN_DOWN))
        ) u_cond (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_btn   (i_btn[g]),
            .o_press (w_press[g])
        );
    end

    assign w_digit        = r_values[{r_cursor, 2'b00} +: 4];
    assign o_values       = r_values;
    assign o_cursor       = r_cursor;
    assign o_commit_valid = r_commit_valid;
    assign o_commit_data  = r_commit_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= EDIT;
            r_values       <= '0;
            r_cursor       <= '0;
            r_commit_valid <= 1'b0;
            r_commit_data  <= '0;
        end else begin
            case (r_state)
                EDIT: begin
                    if (w_press[BTN_ENTER]) begin
                        r_commit_data  <= r_values;
                        r_commit_valid <= 1'b1;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_commit_valid && i_commit_ready) begin
                        r_commit_valid <= 1'b0;
                        r_state        <= EDIT;
                    end
                end
            endcase

            // Enter wins the cycle even in WAIT, where it is then dropped.
            if (!w_press[BTN_ENTER]) begin
                if (w_press[BTN_UP]) begin
                    r_values[{r_cursor, 2'b00} +: 4] <= w_digit + 4'd1;
                end else if (w_press[BTN_DOWN]) begin
                    r_values[{r_cursor, 2'b00} +: 4] <= w_digit - 4'd1;
                end else if (w_press[BTN_LEFT]) begin
                    r_cursor <= (r_cursor == CW'(DIGITS - 1)) ? '0 : r_cursor + CW'(1);
                end else if (w_press[BTN_RIGHT]) begin
                    r_cursor <= (r_cursor == '0) ? CW'(DIGITS - 1) : r_cursor - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: history-based reference model, per-cycle
// compare, directed literal scenarios and a randomized button phase.
module tb_hex_entry;

    localparam int NB    = 5;
    localparam int DBW   = 2;
    localparam int RPW   = 4;
    localparam int NDB   = 1 << DBW;
    localparam int NRP   = 1 << RPW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn = '0;
    logic        ready = 1'b0;
    logic [15:0] values;
    logic [1:0]  cursor;
    logic        cvalid;
    logic [15:0] cdata;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    hex_entry #(.DIGITS(4), .DEBOUNCE_BITS(DBW), .REPEAT_BITS(RPW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_btn          (btn),
        .o_values       (values),
        .o_cursor       (cursor),
        .o_commit_valid (cvalid),
        .o_commit_data  (cdata),
        .i_commit_ready (ready)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          rawh[NB][$];
    int          e;
    bit          stab[NB];
    int          lastflip[NB];
    int          rise_e[NB];
    bit          prevpul[NB];
    int          dig[4];
    int          mcur;
    bit          mvalid;
    logic [15:0] mdata;

    function automatic logic [15:0] mval();
        return 16'(dig[0] + dig[1] * 16 + dig[2] * 256 + dig[3] * 4096);
    endfunction

    task automatic model_reset();
        e = 0;
        for (int b = 0; b < NB; b++) begin
            rawh[b].delete();
            stab[b] = 0; lastflip[b] = 0; rise_e[b] = 0; prevpul[b] = 0;
        end
        for (int d = 0; d < 4; d++) dig[d] = 0;
        mcur = 0; mvalid = 0; mdata = '0;
    endtask

    function automatic bit raw_at(int b, int k);
        return (k >= 1) ? rawh[b][k-1] : 1'b0;
    endfunction

    task automatic model_step();
        int  prio[5] = '{4, 0, 1, 2, 3};
        int  act;
        bit  wasv;
        bit  pul[NB];
        e++;
        for (int b = 0; b < NB; b++) rawh[b].push_back(btn[b]);

        act = -1;
        for (int i = 0; i < 5; i++) if (act < 0 && prevpul[prio[i]]) act = prio[i];
        wasv = mvalid;
        if (wasv && ready) mvalid = 0;
        case (act)
            4: if (!wasv) begin mdata = mval(); mvalid = 1; end
            0: dig[mcur] = (dig[mcur] + 1) % 16;
            1: dig[mcur] = (dig[mcur] + 15) % 16;
            2: mcur = (mcur + 1) % 4;
            3: mcur = (mcur + 3) % 4;
            default: ;
        endcase

        // press: one cycle after the debounced level rises, then every NRP
        // cycles while held (up/down only)
        for (int b = 0; b < NB; b++) begin
            int held = e - 1 - rise_e[b];
            pul[b] = stab[b] && (held == 0 || (b <= 1 && held > 0 && held % NRP == 0));
        end

        // debounced level flips once the last NDB synchronised samples (all
        // taken since the previous flip) disagree with it
        for (int b = 0; b < NB; b++) begin
            bit ok = 1;
            for (int j = 0; j < NDB; j++) begin
                if (raw_at(b, e - 2 - j) == stab[b] || (e - j) <= lastflip[b]) ok = 0;
            end
            if (ok) begin
                stab[b] = ~stab[b];
                lastflip[b] = e;
                if (stab[b]) rise_e[b] = e;
            end
        end
        for (int b = 0; b < NB; b++) prevpul[b] = pul[b];
    endtask

    always @(posedge clk) if (rst_n) model_step();

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("values", 32'(values), 32'(mval()));
            check("cursor", 32'(cursor), 32'(mcur));
            check("commit_valid", 32'(cvalid), 32'(mvalid));
            check("commit_data", 32'(cdata), 32'(mdata));
        end
    end

    task automatic lit_values(string name, logic [15:0] exp);
        check(name, 32'(values), 32'(exp));
        check({"model ", name}, 32'(mval()), 32'(exp));
    endtask

    task automatic lit_cursor(string name, int exp);
        check(name, 32'(cursor), 32'(exp));
        check({"model ", name}, 32'(mcur), 32'(exp));
    endtask

    task automatic check_zero(string tag);
        check({tag, " values"}, 32'(values), 32'd0);
        check({tag, " cursor"}, 32'(cursor), 32'd0);
        check({tag, " valid"}, 32'(cvalid), 32'd0);
        check({tag, " data"}, 32'(cdata), 32'd0);
    endtask

    // called just after a negedge; drops reset between edges
    task automatic do_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_zero("reset");
        btn = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(int b);
        btn[b] = 1'b1;
        repeat (8) @(negedge clk);
        btn[b] = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    int hold[NB];
    bit lvl[NB];

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        cmp_en = 1'b1;

        // glitch of 3 cycles is rejected
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);
        lit_values("glitch", 16'h0000);

        // single press: value appears exactly 8 cycles after the raw edge
        btn[0] = 1'b1;
        repeat (7) @(negedge clk);
        lit_values("press t7", 16'h0000);
        @(negedge clk);
        lit_values("press t8", 16'h0001);
        repeat (2) @(negedge clk);
        btn[0] = 1'b0;
        repeat (10) @(negedge clk);
        lit_values("single press", 16'h0001);
        lit_cursor("single cursor", 0);

        press(1);
        lit_values("down", 16'h0000);
        press(1);
        lit_values("down wrap", 16'h000F);

        // cursor wrap
        do_reset();
        press(3);
        lit_cursor("right wrap", 3);
        press(0);
        press(0);
        lit_values("digit3 up", 16'h2000);
        press(2);
        lit_cursor("left wrap", 0);

        // auto-repeat through F -> 0 -> 1
        press(1);
        press(1);
        lit_values("pre repeat", 16'h200E);
        btn[0] = 1'b1;
        repeat (8) @(negedge clk);
        lit_values("repeat 1", 16'h200F);
        repeat (16) @(negedge clk);
        lit_values("repeat 2", 16'h2000);
        repeat (16) @(negedge clk);
        lit_values("repeat 3", 16'h2001);
        repeat (5) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        lit_values("repeat end", 16'h2001);

        // commit handshake
        do_reset();
        press(1);
        press(2); press(1); press(1);
        press(2); press(1); press(1);
        press(2);
        for (int i = 0; i < 5; i++) press(1);
        lit_values("beef", 16'hBEEF);
        press(4);
        check("commit valid", 32'(cvalid), 32'd1);
        check("commit data", 32'(cdata), 32'h0000BEEF);
        press(2);
        press(0);
        lit_values("bee0", 16'hBEE0);
        press(4);
        check("held data", 32'(cdata), 32'h0000BEEF);
        check("held valid", 32'(cvalid), 32'd1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("accepted", 32'(cvalid), 32'd0);

        // priority: up beats right
        btn[0] = 1'b1;
        btn[3] = 1'b1;
        repeat (8) @(negedge clk);
        btn = '0;
        repeat (10) @(negedge clk);
        lit_values("priority", 16'hBEE1);
        lit_cursor("priority cursor", 0);

        // async reset in WAIT with a debounce in flight
        press(4);
        check("wait valid", 32'(cvalid), 32'd1);
        btn[0] = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (10) @(negedge clk);
        check_zero("post reset");

        // randomized phase
        for (int b = 0; b < NB; b++) begin hold[b] = 0; lvl[b] = 0; end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NB; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = ($urandom_range(0, 2) == 0);
                    hold[b] = $urandom_range(1, 25);
                end
                btn[b] = lvl[b];
                hold[b]--;
            end
            ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        btn = '0;
        ready = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
